// File: rtl/uart_rx_frame_ctrl.sv
// Frame assembler behind a UART byte receiver: SOF, LEN, payload, XOR checksum.
// A good frame is buffered, then drained over a valid/ready stream.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF           = 8'hA5,
    parameter int         MAX_LEN       = 8,
    parameter int         TIMEOUT_TICKS = 320
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       baud_tick,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       frame_ok,
    output logic       err_len,
    output logic       err_chk,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic [7:0] frame_cnt
);

    localparam int                TMO_W     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    function automatic logic [7:0] chk_upd(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [3:0]       len_r, wr_idx_r, rd_idx_r, rd_nxt_s;
    logic [7:0]       chk_r;
    logic [7:0]       buf_r [0:15];
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             out_valid_r, out_last_r;
    logic [7:0]       out_data_r, frame_cnt_r;
    logic             frame_ok_r, err_len_r, err_chk_r, err_timeout_r, err_overrun_r;
    logic             frame_ok_s, err_len_s, err_chk_s, err_timeout_s, err_overrun_s;
    logic             in_frame_s, in_frame_nxt_s, tmo_hit_s, tmo_clr_s;
    logic             len_bad_s, last_wr_s, xfer_s;

    assign in_frame_s     = (state_r == ST_LEN) || (state_r == ST_PAYLOAD) || (state_r == ST_CHK);
    assign in_frame_nxt_s = (state_nxt_s == ST_LEN) || (state_nxt_s == ST_PAYLOAD) ||
                            (state_nxt_s == ST_CHK);
    // A byte arriving on the expiring tick wins over the timeout.
    assign tmo_hit_s      = in_frame_s && baud_tick && (tmo_cnt_r == TMO_LAST) && !rx_done;
    assign tmo_clr_s      = !in_frame_nxt_s || (rx_done && in_frame_s);
    assign len_bad_s      = (rx_data == 8'd0) || (rx_data > MAX_LEN_B);
    assign last_wr_s      = (wr_idx_r == (len_r - 4'd1));
    assign xfer_s         = out_valid_r && out_ready;
    assign rd_nxt_s       = rd_idx_r + 4'd1;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and pulse decode
    always_comb begin
        state_nxt_s   = state_r;
        frame_ok_s    = 1'b0;
        err_len_s     = 1'b0;
        err_chk_s     = 1'b0;
        err_timeout_s = 1'b0;
        err_overrun_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_done && (rx_data == SOF)) begin
                    state_nxt_s = ST_LEN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (rx_done) begin
                    if (len_bad_s) begin
                        err_len_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end else if (tmo_hit_s) begin
                    err_timeout_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (rx_done) begin
                    if (last_wr_s) begin
                        state_nxt_s = ST_CHK;
                    end else begin
                        state_nxt_s = ST_PAYLOAD;
                    end
                end else if (tmo_hit_s) begin
                    err_timeout_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                if (rx_done) begin
                    if (rx_data == chk_r) begin
                        frame_ok_s  = 1'b1;
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        err_chk_s   = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else if (tmo_hit_s) begin
                    err_timeout_s = 1'b1;
                    state_nxt_s   = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
            ST_DRAIN: begin
                err_overrun_s = rx_done;
                if (xfer_s && out_last_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Payload buffer; contents are only read after a complete, checked frame
    always_ff @(posedge clk) begin
        if ((state_r == ST_PAYLOAD) && rx_done) begin
            buf_r[wr_idx_r] <= rx_data;
        end
    end

    // Datapath, timeout counter, output stream and registered pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_r         <= 4'd0;
            wr_idx_r      <= 4'd0;
            rd_idx_r      <= 4'd0;
            chk_r         <= 8'd0;
            tmo_cnt_r     <= '0;
            out_valid_r   <= 1'b0;
            out_data_r    <= 8'd0;
            out_last_r    <= 1'b0;
            frame_cnt_r   <= 8'd0;
            frame_ok_r    <= 1'b0;
            err_len_r     <= 1'b0;
            err_chk_r     <= 1'b0;
            err_timeout_r <= 1'b0;
            err_overrun_r <= 1'b0;
        end else begin
            frame_ok_r    <= frame_ok_s;
            err_len_r     <= err_len_s;
            err_chk_r     <= err_chk_s;
            err_timeout_r <= err_timeout_s;
            err_overrun_r <= err_overrun_s;
            if (frame_ok_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            if (tmo_clr_s) begin
                tmo_cnt_r <= '0;
            end else if (baud_tick && in_frame_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            case (state_r)
                ST_LEN: begin
                    if (rx_done && !len_bad_s) begin
                        len_r    <= rx_data[3:0];
                        chk_r    <= rx_data;
                        wr_idx_r <= 4'd0;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_done) begin
                        chk_r    <= chk_upd(chk_r, rx_data);
                        wr_idx_r <= wr_idx_r + 4'd1;
                    end
                end
                ST_CHK: begin
                    if (frame_ok_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= buf_r[0];
                        out_last_r  <= (len_r == 4'd1);
                        rd_idx_r    <= 4'd0;
                    end
                end
                ST_DRAIN: begin
                    if (xfer_s) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_data_r  <= 8'd0;
                            out_last_r  <= 1'b0;
                            rd_idx_r    <= 4'd0;
                        end else begin
                            rd_idx_r   <= rd_nxt_s;
                            out_data_r <= buf_r[rd_nxt_s];
                            out_last_r <= (rd_nxt_s == (len_r - 4'd1));
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_last    = out_last_r;
    assign frame_ok    = frame_ok_r;
    assign err_len     = err_len_r;
    assign err_chk     = err_chk_r;
    assign err_timeout = err_timeout_r;
    assign err_overrun = err_overrun_r;
    assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good/bad frames, timeout, overrun, reset.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       out_ready = 1'b0;
    logic       out_valid, out_last, frame_ok;
    logic       err_len, err_chk, err_timeout, err_overrun;
    logic [7:0] out_data, frame_cnt;

    int n_vec = 0;
    int n_miss = 0;
    int c_ok, c_len, c_chk, c_tmo, c_ovr;
    logic [7:0] q_data [$];
    logic       q_last [$];

    uart_rx_frame_ctrl dut (
        .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .rx_done(rx_done),
        .rx_data(rx_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_ok(frame_ok),
        .err_len(err_len), .err_chk(err_chk), .err_timeout(err_timeout),
        .err_overrun(err_overrun), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters and drained-byte capture, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_ok)    c_ok++;
        if (err_len)     c_len++;
        if (err_chk)     c_chk++;
        if (err_timeout) c_tmo++;
        if (err_overrun) c_ovr++;
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        c_ok = 0; c_len = 0; c_chk = 0; c_tmo = 0; c_ovr = 0;
        q_data.delete();
        q_last.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            baud_tick = 1'b1;
            @(posedge clk); #1;
            baud_tick = 1'b0;
        end
    endtask

    // exp_bytes holds byte i in bits [8*i +: 8]; out_last expected only on the final byte
    task automatic check_drain(input string tag, input int n, input logic [31:0] exp_bytes);
        check({tag, "_count"}, q_data.size(), n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, (i < q_data.size()) ? {24'd0, q_data[i]} : 32'hDEAD,
                  {24'd0, exp_bytes[8*i +: 8]});
            check({tag, "_last"}, (i < q_last.size()) ? {31'd0, q_last[i]} : 32'hDEAD,
                  (i == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        clear_mon();
        idle(3);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_last", out_last, 1'b0);
        check("rst_cnt", frame_cnt, 8'h00);
        check("rst_pulses", {frame_ok, err_len, err_chk, err_timeout, err_overrun}, 5'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        idle(2);

        // Good 3-byte frame
        clear_mon();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        idle(8);
        check("good_ok", c_ok, 1);
        check_drain("good", 3, 32'h00332211);
        check("good_cnt", frame_cnt, 8'd1);
        check("good_valid_after", out_valid, 1'b0);

        // Checksum error, then a good 1-byte frame
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        send_byte(8'h20); send_byte(8'h00);
        idle(4);
        check("chk_err", c_chk, 1);
        check("chk_nodrain", q_data.size(), 0);
        check("chk_cnt", frame_cnt, 8'd1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        idle(6);
        check("chk_next_ok", c_ok, 1);
        check_drain("chk_next", 1, 32'h0000007E);
        check("chk_next_cnt", frame_cnt, 8'd2);

        // Junk before SOF, zero and oversize lengths
        clear_mon();
        send_byte(8'h55); send_byte(8'hFF);
        idle(2);
        check("junk_noerr", c_len + c_chk + c_tmo + c_ovr, 0);
        send_byte(8'hA5); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h09);
        idle(3);
        check("len_err", c_len, 2);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
        idle(6);
        check("len_recover_ok", c_ok, 1);
        check("len_recover_chk", c_chk, 0);
        check("len_cnt", frame_cnt, 8'd3);

        // Inter-byte timeout
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
        tick_n(319);
        check("tmo_319", c_tmo, 0);
        tick_n(1);
        idle(3);
        check("tmo_320", c_tmo, 1);
        send_byte(8'h10);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
        idle(6);
        check("tmo_idle_chk", c_chk, 0);
        check("tmo_recover_ok", c_ok, 1);
        check("tmo_cnt", frame_cnt, 8'd4);

        // Byte arriving on the expiring tick is accepted
        clear_mon();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44);
        tick_n(319);
        @(posedge clk); #1;
        baud_tick = 1'b1; rx_done = 1'b1; rx_data = 8'h45;
        @(posedge clk); #1;
        baud_tick = 1'b0; rx_done = 1'b0;
        idle(6);
        check("tick_rx_tmo", c_tmo, 0);
        check("tick_rx_ok", c_ok, 1);
        check("tick_rx_cnt", frame_cnt, 8'd5);

        // Back-pressure with overrun during drain
        clear_mon();
        out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hC1);
        send_byte(8'hC2); send_byte(8'h01);
        idle(3);
        check("ovr_valid", out_valid, 1'b1);
        check("ovr_data0", out_data, 8'hC1);
        check("ovr_last0", out_last, 1'b0);
        send_byte(8'h77);
        idle(5);
        check("ovr_pulse", c_ovr, 1);
        check("ovr_hold", out_data, 8'hC1);
        check("ovr_nodrain", q_data.size(), 0);
        out_ready = 1'b1;
        idle(5);
        check_drain("ovr", 2, 32'h0000C2C1);
        check("ovr_valid_after", out_valid, 1'b0);
        check("ovr_cnt", frame_cnt, 8'd6);

        // Reset in the middle of a payload
        clear_mon();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_cnt", frame_cnt, 8'd0);
        check("mid_rst_outs", {out_valid, out_last, out_data}, 10'd0);
        idle(2);
        rstn = 1'b1;
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
        send_byte(8'hBB); send_byte(8'h13);
        idle(6);
        check("post_rst_ok", c_ok, 1);
        check("post_rst_chk", c_chk, 0);
        check_drain("post_rst", 2, 32'h0000BBAA);
        check("post_rst_cnt", frame_cnt, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
